order_tx_framer: RTL and testbench
==================================

ORDER_TX_FRAMER -- requirements
Module: order_tx_framer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of approved orders buffered (power of two, 2..16).
REQ-002 Parameter START_BYTE, default 8'hA5, first byte of every frame.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ord_valid  input  1  one-cycle pulse: approved order from the risk-check stage; no back-pressure upstream.
REQ-006 ord_side  input  1  1 = buy, 0 = sell.
REQ-007 ord_price  input  PRICE_W  order price.
REQ-008 ord_qty  input  SIZE_W  order quantity.
REQ-009 ord_ts  input  TS_W  approval timestamp.
REQ-010 tx_ready  input  1  downstream MAC/UART accepts tx_data this cycle.
REQ-011 tx_valid  output  1  tx_data is valid.
REQ-012 tx_data  output  8  frame byte.
REQ-013 tx_last  output  1  high with the final (checksum) byte.
REQ-014 fifo_level  output  clog2(FIFO_DEPTH)+1  orders currently buffered.
REQ-015 drop_count  output  16  orders lost to overflow, saturating at 16'hFFFF.
REQ-016 seq_out  output  16  sequence number of the next frame to be started.

Function
REQ-017 Frame: 17 bytes, big-endian: B0 = START_BYTE; B1 = {7'b0, side}; B2-B3 = seq; B4-B7 = price zero-extended to 32; B8-B11 = qty zero-extended to 32; B12-B15 = ts[31:0]; B16 = XOR of B0..B15.
REQ-018 PRICE_W, SIZE_W SHALL be <=32 and TS_W >=32; elaboration error otherwise.
REQ-019 Byte transfer occurs on a cycle with tx_valid && tx_ready; tx_data/tx_last SHALL hold stable while tx_valid && !tx_ready.
REQ-020 FSM states IDLE, SEND; IDLE->SEND when FIFO non-empty (head is latched, byte index = 0); SEND->IDLE after transfer of B16 if FIFO empty, else SEND->SEND loading next head with no idle cycle between frames.
REQ-021 First byte of a frame SHALL be presented on tx_valid the cycle after ord_valid when FIFO was empty and FSM idle (1-cycle ingress latency).
REQ-022 An order is popped from the FIFO when its frame is loaded; seq is assigned at load, then seq increments by 1 modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-023 Checksum SHALL be accumulated byte by byte as transmitted, not precomputed over stored fields.
REQ-024 ord_valid with FIFO full and no pop in the same cycle: order dropped, drop_count +1 (saturating), FIFO and seq unchanged.
REQ-025 ord_valid with FIFO full and a pop in the same cycle: order accepted, level unchanged.
REQ-026 ord_valid on consecutive cycles SHALL each be accepted while space exists.
REQ-027 fifo_level excludes the frame currently in SEND.

Reset
REQ-028 On rst: tx_valid=0, tx_data=0, tx_last=0, FSM=IDLE, byte index=0, FIFO empty, fifo_level=0, drop_count=0, seq=0, checksum=0.
REQ-029 rst asserted mid-frame SHALL abort the frame immediately; no partial frame resumes after release.
REQ-030 First frame after rst release SHALL carry seq 0x0000.

Structure
REQ-031 PRICE_W, SIZE_W, TS_W, frame length (17), and START_BYTE default SHALL come from the shared defs header.
REQ-032 The order buffer SHALL be a sub-module order_fifo (synchronous FIFO, width 1+PRICE_W+SIZE_W+TS_W, full/empty/level outputs).

Verification
REQ-033 Single order side=1, price=0x00000064, qty=0x0000000A, ts=0x00000010, tx_ready=1 -> bytes A5 01 00 00 00 00 00 64 00 00 00 0A 00 00 00 10 then checksum = A5^01^64^0A^10 = 0xDA with tx_last; first byte 1 cycle after ord_valid.
REQ-034 Same order with tx_ready toggling 1/0 each cycle -> identical byte sequence, data stable during stalls, 34 cycles to complete.
REQ-035 Six ord_valid pulses on consecutive cycles, tx_ready=0 -> 1 in SEND, 4 in FIFO, 1 dropped: drop_count=1, fifo_level=4; release tx_ready -> 5 back-to-back frames, seq 0..4.
REQ-036 Preset seq to 0xFFFF via 65535 frames (or force) -> next frames carry FFFF then 0000.
REQ-037 rst asserted at byte 7 of a frame with 2 orders queued -> tx_valid=0 next edge, fifo_level=0, no further bytes until new ord_valid; next frame seq 0000.
REQ-038 FIFO full, ord_valid coincident with frame load -> order accepted, drop_count unchanged.

Source files
------------

// File: rtl/order_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : order_tx_framer_pkg
//  Purpose  : Shared widths, frame constants, order record and byte helper
//             for the order transmit framer.
//  Revision : 1.0  initial release
// ============================================================================
package order_tx_framer_pkg;

    localparam int PRICE_W = 32;
    localparam int SIZE_W  = 24;
    localparam int TS_W    = 32;

    localparam int         c_FRAME_LEN      = 17;
    localparam logic [7:0] c_START_BYTE_DEF = 8'hA5;
    localparam int         c_ORDER_W        = 1 + PRICE_W + SIZE_W + TS_W;
    localparam int         c_IDX_W          = 5;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_FRAME_LEN - 1);

    // Framer states
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    typedef struct packed {
        logic               side;
        logic [PRICE_W-1:0] price;
        logic [SIZE_W-1:0]  qty;
        logic [TS_W-1:0]    ts;
    } order_t;

    // Header byte idx (0..15) of a frame; the checksum byte is not handled here.
    function automatic logic [7:0] frame_byte(
        input logic [7:0]         start,
        input logic               side,
        input logic [15:0]        seq,
        input logic [31:0]        price,
        input logic [31:0]        qty,
        input logic [31:0]        ts,
        input logic [c_IDX_W-1:0] idx
    );
        logic [127:0] hdr;
        logic [7:0]   b;
        hdr = {start, 7'b0, side, seq, price, qty, ts};
        b   = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (idx == c_IDX_W'(i)) begin
                b = hdr[127 - 8*i -: 8];
            end
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/order_tx_framer_if.sv
`default_nettype none
// ============================================================================
//  Module   : order_tx_framer_if
//  Purpose  : Order ingress, byte stream egress and status signals of the
//             framer. slave = framer side, master = upstream/downstream side.
//  Revision : 1.0  initial release
// ============================================================================
interface order_tx_framer_if #(
    parameter int FIFO_DEPTH = 4
) ();
    import order_tx_framer_pkg::*;

    logic                        ord_valid;
    logic                        ord_side;
    logic [PRICE_W-1:0]          ord_price;
    logic [SIZE_W-1:0]           ord_qty;
    logic [TS_W-1:0]             ord_ts;
    logic                        tx_ready;
    logic                        tx_valid;
    logic [7:0]                  tx_data;
    logic                        tx_last;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic [15:0]                 drop_count;
    logic [15:0]                 seq_out;

    modport slave (
        input  ord_valid, ord_side, ord_price, ord_qty, ord_ts, tx_ready,
        output tx_valid, tx_data, tx_last, fifo_level, drop_count, seq_out
    );

    modport master (
        output ord_valid, ord_side, ord_price, ord_qty, ord_ts, tx_ready,
        input  tx_valid, tx_data, tx_last, fifo_level, drop_count, seq_out
    );

endinterface
`default_nettype wire

// File: rtl/order_tx_framer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : order_fifo
//  Purpose  : Synchronous show-ahead FIFO holding approved orders. The caller
//             never pops when empty and never pushes when full without a pop.
//  Revision : 1.0  initial release
// ============================================================================
module order_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    i_push,
    input  wire  [WIDTH-1:0]       i_wdata,
    input  wire                    i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] w_mem_d [DEPTH];
    logic [c_AW-1:0]  r_wr_q, w_wr_d;
    logic [c_AW-1:0]  r_rd_q, w_rd_d;
    logic [c_AW:0]    r_level_q, w_level_d;

    // Next storage contents, pointers and occupancy.
    always_comb begin
        w_mem_d   = r_mem_q;
        w_wr_d    = r_wr_q;
        w_rd_d    = r_rd_q;
        w_level_d = r_level_q;
        if (i_push) begin
            w_mem_d[r_wr_q] = i_wdata;
            w_wr_d          = r_wr_q + c_AW'(1);
        end
        if (i_pop) begin
            w_rd_d = r_rd_q + c_AW'(1);
        end
        case ({i_push, i_pop})
            2'b10:   w_level_d = r_level_q + (c_AW+1)'(1);
            2'b01:   w_level_d = r_level_q - (c_AW+1)'(1);
            default: w_level_d = r_level_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_wr_q    <= '0;
            r_rd_q    <= '0;
            r_level_q <= '0;
        end else begin
            r_mem_q   <= w_mem_d;
            r_wr_q    <= w_wr_d;
            r_rd_q    <= w_rd_d;
            r_level_q <= w_level_d;
        end
    end

    assign o_rdata = r_mem_q[r_rd_q];
    assign o_full  = (r_level_q == (c_AW+1)'(DEPTH));
    assign o_empty = (r_level_q == '0);
    assign o_level = r_level_q;

endmodule
`default_nettype wire

// File: rtl/order_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : order_tx_framer
//  Purpose  : Buffers approved orders and serialises each into a 17-byte
//             frame (start, side, seq, price, qty, ts, XOR checksum).
//  Revision : 1.0  initial release
// ============================================================================
module order_tx_framer
    import order_tx_framer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] START_BYTE = c_START_BYTE_DEF
) (
    input wire               clk,
    input wire               rst,
    order_tx_framer_if.slave bus
);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    if (PRICE_W > 32 || SIZE_W > 32 || TS_W < 32) begin : g_bad_widths
        $error("order_tx_framer: PRICE_W/SIZE_W must be <= 32 and TS_W >= 32");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("order_tx_framer: FIFO_DEPTH must be a power of two in 2..16");
    end

    order_t               w_in, w_head, w_next_ord;
    logic                 w_fifo_full, w_fifo_empty;
    logic [c_LVL_W-1:0]   w_fifo_level;
    logic                 w_tx_valid, w_tx_last;
    logic [7:0]           w_tx_data;
    logic                 w_xfer, w_last_xfer, w_avail, w_load, w_pop, w_push, w_drop;

    logic [0:0]           r_state_q, w_state_d;
    logic                 r_side_q, w_side_d;
    logic [31:0]          r_price_q, w_price_d;
    logic [31:0]          r_qty_q, w_qty_d;
    logic [31:0]          r_ts_q, w_ts_d;
    logic [15:0]          r_fseq_q, w_fseq_d;
    logic [15:0]          r_seq_q, w_seq_d;
    logic [c_IDX_W-1:0]   r_idx_q, w_idx_d;
    logic [7:0]           r_csum_q, w_csum_d;
    logic [15:0]          r_drop_q, w_drop_d;

    assign w_in = {bus.ord_side, bus.ord_price, bus.ord_qty, bus.ord_ts};

    // A frame is loaded when the framer is idle or its last byte is leaving;
    // with an empty FIFO the incoming order bypasses straight into the frame.
    assign w_xfer      = w_tx_valid && bus.tx_ready;
    assign w_last_xfer = w_xfer && (r_idx_q == c_LAST_IDX);
    assign w_avail     = !w_fifo_empty || bus.ord_valid;
    assign w_load      = ((r_state_q == c_ST_IDLE) || w_last_xfer) && w_avail;
    assign w_pop       = w_load && !w_fifo_empty;
    assign w_push      = bus.ord_valid && !(w_load && w_fifo_empty) && (!w_fifo_full || w_pop);
    assign w_drop      = bus.ord_valid && w_fifo_full && !w_pop;
    assign w_next_ord  = w_fifo_empty ? w_in : w_head;

    order_fifo #(
        .WIDTH (c_ORDER_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_in),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= c_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // FSM next state: stay in SEND while orders keep arriving back to back.
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: if (w_avail) w_state_d = c_ST_SEND;
            c_ST_SEND: if (w_last_xfer && !w_avail) w_state_d = c_ST_IDLE;
            default:   w_state_d = c_ST_IDLE;
        endcase
    end

    // FSM outputs: current frame byte, checksum on the final index.
    always_comb begin
        w_tx_valid = (r_state_q == c_ST_SEND);
        w_tx_last  = 1'b0;
        w_tx_data  = 8'h00;
        if (w_tx_valid) begin
            if (r_idx_q == c_LAST_IDX) begin
                w_tx_data = r_csum_q;
                w_tx_last = 1'b1;
            end else begin
                w_tx_data = frame_byte(START_BYTE, r_side_q, r_fseq_q,
                                       r_price_q, r_qty_q, r_ts_q, r_idx_q);
            end
        end
    end

    // Frame fields, byte index, running checksum, sequence and drop counters.
    always_comb begin
        w_side_d  = r_side_q;
        w_price_d = r_price_q;
        w_qty_d   = r_qty_q;
        w_ts_d    = r_ts_q;
        w_fseq_d  = r_fseq_q;
        w_seq_d   = r_seq_q;
        w_idx_d   = r_idx_q;
        w_csum_d  = r_csum_q;
        w_drop_d  = r_drop_q;
        if (w_load) begin
            w_side_d  = w_next_ord.side;
            w_price_d = 32'(w_next_ord.price);
            w_qty_d   = 32'(w_next_ord.qty);
            w_ts_d    = w_next_ord.ts[31:0];
            w_fseq_d  = r_seq_q;
            w_seq_d   = r_seq_q + 16'd1;
            w_idx_d   = '0;
            w_csum_d  = '0;
        end else if (w_xfer) begin
            if (w_last_xfer) begin
                w_idx_d  = '0;
                w_csum_d = '0;
            end else begin
                w_idx_d  = r_idx_q + c_IDX_W'(1);
                w_csum_d = r_csum_q ^ w_tx_data;
            end
        end
        if (w_drop && (r_drop_q != 16'hFFFF)) begin
            w_drop_d = r_drop_q + 16'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_side_q  <= 1'b0;
            r_price_q <= '0;
            r_qty_q   <= '0;
            r_ts_q    <= '0;
            r_fseq_q  <= '0;
            r_seq_q   <= '0;
            r_idx_q   <= '0;
            r_csum_q  <= '0;
            r_drop_q  <= '0;
        end else begin
            r_side_q  <= w_side_d;
            r_price_q <= w_price_d;
            r_qty_q   <= w_qty_d;
            r_ts_q    <= w_ts_d;
            r_fseq_q  <= w_fseq_d;
            r_seq_q   <= w_seq_d;
            r_idx_q   <= w_idx_d;
            r_csum_q  <= w_csum_d;
            r_drop_q  <= w_drop_d;
        end
    end

    assign bus.tx_valid   = w_tx_valid;
    assign bus.tx_data    = w_tx_data;
    assign bus.tx_last    = w_tx_last;
    assign bus.fifo_level = w_fifo_level;
    assign bus.drop_count = r_drop_q;
    assign bus.seq_out    = r_seq_q;

endmodule
`default_nettype wire

// File: tb/tb_order_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_order_tx_framer
//  Purpose  : Directed and random stimulus for order_tx_framer, checked
//             against a queue-based frame model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_order_tx_framer;
    import order_tx_framer_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    order_tx_framer_if #(.FIFO_DEPTH(DEPTH)) bus ();

    order_tx_framer #(
        .FIFO_DEPTH (DEPTH),
        .START_BYTE (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        side;
        logic [31:0] price;
        logic [31:0] qty;
        logic [31:0] ts;
    } ord_s;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          last_xfer_cyc = 0;
    logic        drv_valid;
    logic        drv_ready;
    ord_s        drv_ord;
    ord_s        pend[$];
    logic        m_busy;
    int          m_idx;
    logic [7:0]  m_frame [17];
    logic [15:0] m_seq;
    int          m_drop;
    logic [7:0]  got[$];
    logic [7:0]  exp33 [17];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: build the expected 17 bytes of a frame from order fields.
    task automatic start_frame(input ord_s o);
        logic [31:0] p, q, t;
        logic [7:0]  x;
        p = 32'(o.price[PRICE_W-1:0]);
        q = 32'(o.qty[SIZE_W-1:0]);
        t = o.ts;
        m_frame[0] = 8'hA5;
        m_frame[1] = {7'b0, o.side};
        m_frame[2] = m_seq[15:8];
        m_frame[3] = m_seq[7:0];
        for (int k = 0; k < 4; k++) begin
            m_frame[4+k]  = 8'(p >> (24 - 8*k));
            m_frame[8+k]  = 8'(q >> (24 - 8*k));
            m_frame[12+k] = 8'(t >> (24 - 8*k));
        end
        x = 8'h00;
        for (int k = 0; k < 16; k++) x = x ^ m_frame[k];
        m_frame[16] = x;
        m_seq  = m_seq + 16'd1;
        m_busy = 1'b1;
        m_idx  = 0;
    endtask

    task automatic rand_ord();
        drv_ord.side  = 1'($urandom);
        drv_ord.price = $urandom;
        drv_ord.qty   = $urandom;
        drv_ord.ts    = $urandom;
    endtask

    // One clock: drive at negedge, check against the model, then advance it.
    task automatic cycle();
        logic xfer, lastx;
        @(negedge clk);
        bus.ord_valid = drv_valid;
        bus.ord_side  = drv_ord.side;
        bus.ord_price = drv_ord.price[PRICE_W-1:0];
        bus.ord_qty   = drv_ord.qty[SIZE_W-1:0];
        bus.ord_ts    = TS_W'(drv_ord.ts);
        bus.tx_ready  = drv_ready;
        #1;
        cyc++;
        chk("tx_valid", bus.tx_valid, m_busy);
        if (m_busy) begin
            chk("tx_data", bus.tx_data, m_frame[m_idx]);
            chk("tx_last", bus.tx_last, m_idx == 16);
        end
        chk("fifo_level", bus.fifo_level, pend.size());
        chk("drop_count", bus.drop_count, m_drop);
        chk("seq_out", bus.seq_out, m_seq);
        xfer  = m_busy && drv_ready;
        lastx = xfer && (m_idx == 16);
        if (xfer) begin
            got.push_back(bus.tx_data);
            if (lastx) last_xfer_cyc = cyc;
            else       m_idx++;
        end
        if (!m_busy || lastx) begin
            if (pend.size() > 0) begin
                start_frame(pend.pop_front());
                if (drv_valid) pend.push_back(drv_ord);
            end else if (drv_valid) begin
                start_frame(drv_ord);
            end else begin
                m_busy = 1'b0;
            end
        end else if (drv_valid) begin
            if (pend.size() < DEPTH) pend.push_back(drv_ord);
            else if (m_drop < 65535) m_drop++;
        end
        drv_valid = 1'b0;
    endtask

    task automatic model_clear();
        pend.delete();
        m_busy = 1'b0;
        m_idx  = 0;
        m_seq  = 16'h0000;
        m_drop = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, bus.tx_valid, 0);
        chk({tag, "_tx_data"}, bus.tx_data, 0);
        chk({tag, "_tx_last"}, bus.tx_last, 0);
        chk({tag, "_fifo_level"}, bus.fifo_level, 0);
        chk({tag, "_drop_count"}, bus.drop_count, 0);
        chk({tag, "_seq_out"}, bus.seq_out, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((m_busy || pend.size() > 0) && n < max) begin
            cycle();
            n++;
        end
        chk("drain_timeout", (m_busy || pend.size() > 0), 0);
    endtask

    task automatic check_exp33(input string tag);
        chk({tag, "_len"}, got.size(), 17);
        if (got.size() == 17) begin
            for (int k = 0; k < 17; k++) chk(tag, got[k], exp33[k]);
        end
    endtask

    initial begin
        #2000000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp33 = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h64,
                  8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDA};
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        drv_ord   = '0;
        model_clear();
        bus.ord_valid = 1'b0;
        bus.ord_side  = 1'b0;
        bus.ord_price = '0;
        bus.ord_qty   = '0;
        bus.ord_ts    = '0;
        bus.tx_ready  = 1'b0;

        // Power-on reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;

        // Single order, always ready: fixed byte image, 1-cycle latency
        got.delete();
        drv_ord   = '{side: 1'b1, price: 32'h64, qty: 32'h0A, ts: 32'h10};
        drv_valid = 1'b1;
        drv_ready = 1'b1;
        cycle();
        chk("latency_valid", m_busy, 1);
        drain(100);
        check_exp33("single");

        // Same order, ready toggling from the first presented byte
        do_reset();
        got.delete();
        drv_ord   = '{side: 1'b1, price: 32'h64, qty: 32'h0A, ts: 32'h10};
        drv_valid = 1'b1;
        drv_ready = 1'b0;
        cycle();
        begin
            int t0;
            t0 = cyc;
            for (int k = 0; k < 100 && (m_busy || pend.size() > 0); k++) begin
                drv_ready = (k % 2 == 0);
                cycle();
            end
            chk("toggle_done", m_busy, 0);
            chk("toggle_cycles", last_xfer_cyc - t0 + 1, 34);
        end
        check_exp33("toggle");

        // Six back-to-back orders while stalled: one dropped
        do_reset();
        drv_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rand_ord();
            drv_valid = 1'b1;
            cycle();
        end
        cycle();
        chk("burst_drop", bus.drop_count, 1);
        chk("burst_level", bus.fifo_level, 4);
        drv_ready = 1'b1;
        drain(300);
        chk("burst_seq", bus.seq_out, 5);

        // Full FIFO with an order arriving on the frame-load cycle
        do_reset();
        drv_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_ord();
            drv_valid = 1'b1;
            cycle();
        end
        cycle();
        chk("coinc_full", bus.fifo_level, 4);
        drv_ready = 1'b1;
        for (int k = 0; k < 40 && !(m_busy && m_idx == 16); k++) cycle();
        chk("coinc_reach", (m_busy && m_idx == 16), 1);
        rand_ord();
        drv_valid = 1'b1;
        cycle();
        cycle();
        chk("coinc_level", bus.fifo_level, 4);
        chk("coinc_drop", bus.drop_count, 0);
        drain(300);

        // Sequence wrap FFFF -> 0000
        do_reset();
        @(negedge clk);
        force dut.r_seq_q = 16'hFFFF;
        #1;
        release dut.r_seq_q;
        m_seq = 16'hFFFF;
        drv_ready = 1'b1;
        rand_ord();
        drv_valid = 1'b1;
        cycle();
        rand_ord();
        drv_valid = 1'b1;
        cycle();
        drain(100);
        chk("wrap_seq", bus.seq_out, 1);

        // Reset at byte 7 with two orders queued
        do_reset();
        drv_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_ord();
            drv_valid = 1'b1;
            cycle();
        end
        for (int k = 0; k < 30 && !(m_busy && m_idx == 7); k++) cycle();
        chk("abort_reach", (m_busy && m_idx == 7), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_tx_valid", bus.tx_valid, 0);
        chk("abort_level", bus.fifo_level, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) cycle();
        rand_ord();
        drv_valid = 1'b1;
        cycle();
        drain(100);
        chk("abort_seq", bus.seq_out, 1);

        // Random traffic with random back-pressure
        for (int k = 0; k < 800; k++) begin
            rand_ord();
            drv_valid = ($urandom_range(0, 3) == 0);
            drv_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drv_ready = 1'b1;
        drain(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
